// File: rtl/pwm_capture.sv
// PWM receive-side measurement: synchronizes and filters pwm_in, then reports
// high time, rising-to-rising period and a quarter-step duty level per period.
module pwm_capture #(
    parameter int CNT_W      = 18,
    parameter int PERIOD_MAX = 200000,
    parameter int FILT       = 2
) (
    input  logic             CLK100MHZ,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic [1:0]       duty_lvl,
    output logic             sample_valid,
    output logic             timeout
);

    localparam int              FW      = (FILT > 1) ? $clog2(FILT) : 1;
    localparam int              DW      = CNT_W + 2;
    localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(PERIOD_MAX);
    localparam logic [FW-1:0]    C_FLAST = FW'(FILT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_pwm_f;
    logic             r_pwm_d;
    logic [FW-1:0]    r_filt_cnt;
    state_t           r_state;
    logic             r_primed;
    logic [CNT_W-1:0] r_per_ctr;
    logic [CNT_W-1:0] r_hi_ctr;

    logic             w_rise;
    logic             w_fall;
    logic             w_at_max;
    logic [DW-1:0]    w_h;
    logic [DW-1:0]    w_p;
    logic [DW-1:0]    w_h2;
    logic [DW-1:0]    w_h4;
    logic [DW-1:0]    w_p3;
    logic [1:0]       w_duty;

    // Two-flop synchronizer, then a run-length filter: pwm_f only moves after
    // FILT consecutive synchronized samples disagree with it.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_pwm_f    <= 1'b0;
            r_pwm_d    <= 1'b0;
            r_filt_cnt <= '0;
        end else begin
            r_sync1 <= pwm_in;
            r_sync2 <= r_sync1;
            r_pwm_d <= r_pwm_f;
            if (r_sync2 == r_pwm_f) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == C_FLAST) begin
                r_pwm_f    <= r_sync2;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + FW'(1);
            end
        end
    end

    assign w_rise   = r_pwm_f & ~r_pwm_d;
    assign w_fall   = ~r_pwm_f & r_pwm_d;
    assign w_at_max = (r_per_ctr == C_MAX);

    assign w_h  = DW'(r_hi_ctr);
    assign w_p  = DW'(r_per_ctr);
    assign w_h2 = w_h << 1;
    assign w_h4 = w_h << 2;
    assign w_p3 = (w_p << 1) + w_p;

    // Quarter-step duty classification of the period being closed.
    always_comb begin
        w_duty = 2'd3;
        if (w_h4 < w_p) begin
            w_duty = 2'd0;
        end else if (w_h2 < w_p) begin
            w_duty = 2'd1;
        end else if (w_h4 < w_p3) begin
            w_duty = 2'd2;
        end else begin
            w_duty = 2'd3;
        end
    end

    // Measurement FSM with period/high counters and registered outputs.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_primed     <= 1'b0;
            r_per_ctr    <= '0;
            r_hi_ctr     <= '0;
            high_cnt     <= '0;
            period_cnt   <= '0;
            duty_lvl     <= 2'd0;
            sample_valid <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;

            if (w_rise) begin
                r_per_ctr <= CNT_W'(1);
            end else if (!w_at_max) begin
                r_per_ctr <= r_per_ctr + CNT_W'(1);
            end else begin
                r_per_ctr <= r_per_ctr;
            end

            // A rise at the limit closes the period normally instead of timing out.
            if ((r_state != ST_IDLE) && w_at_max && !w_rise) begin
                sample_valid <= 1'b1;
                high_cnt     <= '0;
                period_cnt   <= '0;
                duty_lvl     <= r_pwm_f ? 2'd3 : 2'd0;
                timeout      <= 1'b1;
                r_primed     <= 1'b0;
                r_state      <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_rise) begin
                            r_state <= ST_HIGH;
                        end
                    end
                    ST_HIGH: begin
                        if (w_fall) begin
                            r_hi_ctr <= r_per_ctr;
                            r_state  <= ST_LOW;
                        end
                    end
                    ST_LOW: begin
                        if (w_rise) begin
                            if (r_primed) begin
                                high_cnt     <= r_hi_ctr;
                                period_cnt   <= r_per_ctr;
                                duty_lvl     <= w_duty;
                                sample_valid <= 1'b1;
                                timeout      <= 1'b0;
                            end
                            r_primed <= 1'b1;
                            r_state  <= ST_HIGH;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized bench for pwm_capture: a timestamp-based reference model pushes
// expected samples into a queue that a monitor drains on every sample_valid.
module tb_pwm_capture;

    localparam int CNT_W = 18;
    localparam int PMAX  = 1000;
    localparam int FILT  = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             pwm_in = 1'b0;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic [1:0]       duty_lvl;
    logic             sample_valid;
    logic             timeout;

    always #5 clk = ~clk;

    pwm_capture #(.CNT_W(CNT_W), .PERIOD_MAX(PMAX), .FILT(FILT)) dut (
        .CLK100MHZ   (clk),
        .reset       (reset),
        .pwm_in      (pwm_in),
        .high_cnt    (high_cnt),
        .period_cnt  (period_cnt),
        .duty_lvl    (duty_lvl),
        .sample_valid(sample_valid),
        .timeout     (timeout)
    );

    typedef struct {
        int hi;
        int per;
        int lvl;
        int to;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp_v);
        end
    endtask

    function automatic int lvl_of(input int hi, input int per);
        real r;
        r = real'(hi) / real'(per);
        if (r < 0.25) return 0;
        if (r < 0.5) return 1;
        if (r < 0.75) return 2;
        return 3;
    endfunction

    // Reference model: filtered level from raw sample history, then periods
    // and high times as differences of rise/fall timestamps.
    bit hist[FILT+1];
    bit f_lvl, f_prev, primed, in_period, seen_fall;
    int t_rise, hi_m;

    always @(posedge clk) begin : model_blk
        bit rise_v, fall_v, same_v;
        int el;
        if (reset) begin
            for (int i = 0; i <= FILT; i++) hist[i] = 1'b0;
            f_lvl = 1'b0; f_prev = 1'b0; primed = 1'b0;
            in_period = 1'b0; seen_fall = 1'b0; t_rise = 0; hi_m = 0;
        end else begin
            rise_v = f_lvl & ~f_prev;
            fall_v = ~f_lvl & f_prev;
            el = cyc - t_rise;
            if (in_period && el >= PMAX && !rise_v) begin
                q.push_back('{0, 0, f_lvl ? 3 : 0, 1, cyc});
                primed = 1'b0;
                in_period = 1'b0;
            end else if (rise_v) begin
                if (in_period && seen_fall) begin
                    if (primed) q.push_back('{hi_m, el, lvl_of(hi_m, el), 0, cyc});
                    primed = 1'b1;
                end
                in_period = 1'b1;
                seen_fall = 1'b0;
                t_rise = cyc;
            end else if (fall_v && in_period && !seen_fall) begin
                hi_m = el;
                seen_fall = 1'b1;
            end
            f_prev = f_lvl;
            same_v = 1'b1;
            for (int i = 1; i <= FILT; i++) if (hist[i] != hist[1]) same_v = 1'b0;
            if (same_v) f_lvl = hist[1];
            for (int i = FILT; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = pwm_in;
        end
    end

    // Monitor: every sample_valid pulse must match the oldest expected sample.
    always @(negedge clk) begin : mon_blk
        exp_t e;
        if (sample_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_sample at cycle %0d: high_cnt %0d period_cnt %0d timeout %0d",
                         cyc, high_cnt, period_cnt, timeout);
            end else begin
                e = q.pop_front();
                chk("sample_cycle", cyc, e.cyc + 1);
                chk("high_cnt", int'(high_cnt), e.hi);
                chk("period_cnt", int'(period_cnt), e.per);
                chk("duty_lvl", int'(duty_lvl), e.lvl);
                chk("timeout", int'(timeout), e.to);
            end
        end
    end

    task automatic seg(input bit lvl, input int n);
        repeat (n) begin
            pwm_in = lvl;
            @(negedge clk);
        end
    endtask

    task automatic pwm_per(input int hh, input int ll);
        seg(1'b1, hh);
        seg(1'b0, ll);
    endtask

    task automatic glitch_per(input int hh, input int ll);
        for (int i = 0; i < hh; i++) begin
            pwm_in = (i % 50 == 25) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        for (int i = 0; i < ll; i++) begin
            pwm_in = (i % 50 == 25) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_high_cnt"}, int'(high_cnt), 0);
        chk({tag, "_period_cnt"}, int'(period_cnt), 0);
        chk({tag, "_duty_lvl"}, int'(duty_lvl), 0);
        chk({tag, "_sample_valid"}, int'(sample_valid), 0);
        chk({tag, "_timeout"}, int'(timeout), 0);
    endtask

    initial begin
        reset  = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;

        repeat (4) pwm_per(250, 750);
        repeat (3) pwm_per(997, 3);
        repeat (3) pwm_per(500, 500);
        repeat (3) glitch_per(400, 400);

        seg(1'b1, 1500);
        repeat (3) pwm_per(100, 300);
        seg(1'b0, 6000);

        repeat (2) pwm_per(300, 700);
        seg(1'b1, 150);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_zero("midreset");
        seg(1'b1, 150);
        seg(1'b0, 700);
        repeat (4) pwm_per(300, 700);

        repeat (30) pwm_per($urandom_range(2, 700), $urandom_range(2, 700));
        seg(1'b0, 2500);

        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
